// File: rtl/ddr4_cmd_pkg.sv
// Shared types and pin encoding for the DDR4 command sequencer.
package ddr4_cmd_pkg;

  typedef enum logic [2:0] {CMD_DES, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF} cmd_e;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_DATA, S_BURST,
    S_WAIT_PRE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
  } state_e;

  localparam int A_W = 17;

  // {RAS_n, CAS_n, WE_n} carried on A[16:14] for non-ACT commands
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_REF = 3'b001;

  typedef struct packed {
    logic           cs_n;
    logic           act_n;
    logic [A_W-1:0] a;
  } pins_t;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic pins_t cmd_pins(input cmd_e cmd, input logic [A_W-1:0] row,
                                     input logic [A_W-1:0] col);
    pins_t p;
    p = '{cs_n: 1'b1, act_n: 1'b1, a: '0};
    case (cmd)
      CMD_ACT: begin p.cs_n = 1'b0; p.act_n = 1'b0; p.a = row; end
      CMD_RD:  begin p.cs_n = 1'b0; p.a = col; p.a[16:14] = RCW_RD; p.a[10] = 1'b0; end
      CMD_WR:  begin p.cs_n = 1'b0; p.a = col; p.a[16:14] = RCW_WR; p.a[10] = 1'b0; end
      CMD_PRE: begin p.cs_n = 1'b0; p.a[16:14] = RCW_PRE; end
      CMD_REF: begin p.cs_n = 1'b0; p.a[16:14] = RCW_REF; end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ddr_wait_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module ddr_wait_counter #(
  parameter int W       = 6,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst)              cnt <= W'(RST_VAL);
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;

  assign done = (cnt == '0);
endmodule

// File: rtl/ddr4_cmd_sequencer.sv
// Closed-page, single-outstanding DDR4 command sequencer (ACT, RD/WR, burst, PRE).
// Optional periodic refresh when REFRESH_EN is defined.
module ddr4_cmd_sequencer
  import ddr4_cmd_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int CHIPS     = 18,
  parameter int DQWIDTH   = 72,
  parameter int BL        = 8,
  parameter int TINIT     = 5,
  parameter int TRCD      = 15,
  parameter int TCL       = 15,
  parameter int TCWL      = 11,
  parameter int TWR       = 16,
  parameter int TRP       = 15
`ifdef REFRESH_EN
  ,
  parameter int TREFI     = 7800,
  parameter int TRFC      = 350
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BGWIDTH-1:0]    req_bg,
  input  logic [BAWIDTH-1:0]    req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [COLWIDTH-1:0]   req_col,
  input  logic [BL*DQWIDTH-1:0] req_wdata,
  output logic                  rd_valid,
  output logic [BL*DQWIDTH-1:0] rd_data,
  output logic                  reset_n,
  output logic                  cke,
  output logic                  cs_n,
  output logic                  act_n,
  output logic [ADDRWIDTH-1:0]  A,
  output logic [BGWIDTH-1:0]    bg,
  output logic [BAWIDTH-1:0]    ba,
  output logic [DQWIDTH-1:0]    dq_out,
  output logic                  dq_oe,
  input  logic [DQWIDTH-1:0]    dq_in,
  output logic [CHIPS-1:0]      dqs_t,
  output logic [CHIPS-1:0]      dqs_c
);
  localparam int MAXT0 = max2(max2(max2(TINIT, TRCD), max2(TCL, TCWL)), max2(TWR, TRP));
`ifdef REFRESH_EN
  localparam int MAXT = max2(MAXT0, TRFC);
`else
  localparam int MAXT = MAXT0;
`endif
  localparam int CW = $clog2(MAXT + BL) + 1;

  // Every wait loads interval-1 on entry to its command state so done marks the last cycle
  localparam logic [CW-1:0] L_RCD = CW'(TRCD - 1);
  localparam logic [CW-1:0] L_CL  = CW'(TCL - 1);
  localparam logic [CW-1:0] L_CWL = CW'(TCWL - 1);
  localparam logic [CW-1:0] L_BL  = CW'(BL - 1);
  localparam logic [CW-1:0] L_WR  = CW'((TWR > 1) ? TWR - 2 : 0);
  localparam logic [CW-1:0] L_RP  = CW'(TRP - 1);

  state_e state, state_nxt;
  cmd_e   cmd_nxt;
  logic   ld, cnt_done, accept, beat_nxt, cap, rd_fin;
  logic [CW-1:0] ld_val;
  logic   wr_q;
  logic [COLWIDTH-1:0]         col_q;
  logic [BL*DQWIDTH-1:0]       wsh;
  logic [(BL-1)*DQWIDTH-1:0]   rsh;
  pins_t  pins;

  ddr_wait_counter #(.W(CW), .RST_VAL(TINIT)) u_wait (
    .clk(clk), .rst(rst), .load(ld), .load_val(ld_val), .done(cnt_done)
  );

`ifdef REFRESH_EN
  localparam int RW = $clog2(TREFI) + 1;
  localparam logic [CW-1:0] L_RFC = CW'(TRFC - 1);
  logic [RW-1:0] ref_cnt;
  logic          ref_pend, ref_clr;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ref_cnt  <= RW'(TREFI - 1);
      ref_pend <= 1'b0;
    end else if (ref_cnt == '0) begin
      ref_cnt  <= RW'(TREFI - 1);
      ref_pend <= 1'b1;
    end else begin
      ref_cnt  <= ref_cnt - 1'b1;
      if (ref_clr) ref_pend <= 1'b0;
    end

  assign req_ready = (state == S_IDLE) && !ref_pend;
`else
  assign req_ready = (state == S_IDLE);
`endif

  always_comb begin
    state_nxt = state;
    cmd_nxt   = CMD_DES;
    ld        = 1'b0;
    ld_val    = '0;
    accept    = 1'b0;
    beat_nxt  = 1'b0;
    cap       = 1'b0;
    rd_fin    = 1'b0;
`ifdef REFRESH_EN
    ref_clr   = 1'b0;
`endif
    case (state)
      S_INIT: if (cnt_done) state_nxt = S_IDLE;
      S_IDLE: begin
`ifdef REFRESH_EN
        if (ref_pend) begin
          state_nxt = S_REF; cmd_nxt = CMD_REF; ld = 1'b1; ld_val = L_RFC;
        end else
`endif
        if (req_valid) begin
          accept = 1'b1; state_nxt = S_ACT; cmd_nxt = CMD_ACT; ld = 1'b1; ld_val = L_RCD;
        end
      end
      S_ACT, S_WAIT_RCD:
        if (cnt_done) begin
          state_nxt = S_RW; cmd_nxt = wr_q ? CMD_WR : CMD_RD;
          ld = 1'b1; ld_val = wr_q ? L_CWL : L_CL;
        end else state_nxt = S_WAIT_RCD;
      S_RW, S_WAIT_DATA:
        if (cnt_done) begin
          state_nxt = S_BURST; ld = 1'b1; ld_val = L_BL; beat_nxt = wr_q;
        end else state_nxt = S_WAIT_DATA;
      S_BURST: begin
        cap = !wr_q;
        if (!cnt_done) beat_nxt = wr_q;
        else begin
          rd_fin = !wr_q;
          if (!wr_q || TWR == 1) begin
            state_nxt = S_PRE; cmd_nxt = CMD_PRE; ld = 1'b1; ld_val = L_RP;
          end else begin
            state_nxt = S_WAIT_PRE; ld = 1'b1; ld_val = L_WR;
          end
        end
      end
      S_WAIT_PRE:
        if (cnt_done) begin
          state_nxt = S_PRE; cmd_nxt = CMD_PRE; ld = 1'b1; ld_val = L_RP;
        end
      S_PRE, S_WAIT_RP: state_nxt = cnt_done ? S_IDLE : S_WAIT_RP;
`ifdef REFRESH_EN
      S_REF, S_WAIT_RFC:
        if (cnt_done) begin
          state_nxt = S_IDLE; ref_clr = 1'b1;
        end else state_nxt = S_WAIT_RFC;
`endif
      default: state_nxt = S_INIT;
    endcase
  end

  // ACT only issues on the accept cycle, so the live req_row is the row to drive
  assign pins = cmd_pins(cmd_nxt, A_W'(req_row), A_W'(col_q));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_INIT;
      reset_n  <= 1'b0;
      cke      <= 1'b0;
      cs_n     <= 1'b1;
      act_n    <= 1'b1;
      A        <= '0;
      bg       <= '0;
      ba       <= '0;
      wr_q     <= 1'b0;
      col_q    <= '0;
      wsh      <= '0;
      rsh      <= '0;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      dqs_t    <= '0;
      dqs_c    <= '1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state   <= state_nxt;
      reset_n <= 1'b1;
      cke     <= 1'b1;
      cs_n    <= pins.cs_n;
      act_n   <= pins.act_n;
      A       <= ADDRWIDTH'(pins.a);
      if (accept) begin
        bg    <= req_bg;
        ba    <= req_ba;
        wr_q  <= req_write;
        col_q <= req_col;
        wsh   <= req_wdata;
      end else if (beat_nxt) begin
        wsh   <= {{DQWIDTH{1'b0}}, wsh[BL*DQWIDTH-1:DQWIDTH]};
      end
      dq_out <= beat_nxt ? wsh[DQWIDTH-1:0] : '0;
      dq_oe  <= beat_nxt;
      dqs_t  <= {CHIPS{beat_nxt}};
      dqs_c  <= {CHIPS{~beat_nxt}};
      if (cap) rsh <= {dq_in, rsh[(BL-1)*DQWIDTH-1:DQWIDTH]};
      rd_valid <= rd_fin;
      if (rd_fin) rd_data <= {dq_in, rsh};
    end

  always_ff @(posedge clk)
    assert (TINIT > 0 && TRCD > 0 && TCL > 0 && TCWL > 0 && TWR > 0 && TRP > 0 &&
            BL > 2 && ADDRWIDTH == A_W)
      else $error("ddr4_cmd_sequencer: illegal parameter");
`ifdef REFRESH_EN
  always_ff @(posedge clk)
    assert (TREFI > 0 && TRFC > 0) else $error("ddr4_cmd_sequencer: illegal refresh timing");
`endif
endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer: reset/init, write, read, back-to-back, mid-burst reset.
module tb_ddr4_cmd_sequencer;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [1:0]   req_bg, req_ba;
  logic [16:0]  req_row;
  logic [9:0]   req_col;
  logic [575:0] req_wdata;
  logic         rd_valid;
  logic [575:0] rd_data;
  logic         reset_n, cke, cs_n, act_n;
  logic [16:0]  A;
  logic [1:0]   bg, ba;
  logic [71:0]  dq_out, dq_in;
  logic         dq_oe;
  logic [17:0]  dqs_t, dqs_c;

  int n_cmp = 0;
  int n_err = 0;

  ddr4_cmd_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .req_wdata(req_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in), .dqs_t(dqs_t), .dqs_c(dqs_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] beat_pat(input int i);
    logic [7:0] hi;
    hi = 8'hA0 + 8'(i);
    return {hi, 64'hC0DE_0000_0000_0000 + 64'(i)};
  endfunction

  // One request to bg=1 ba=1 row=1 col=2; offsets are cycles after the accept cycle
  task automatic txn(input bit wr, input int abort_at);
    int ncs, noe, nrv, rdy_at, rv_at, bad_beats, w;
    logic [575:0] wd, exp_rd;
    for (int i = 0; i < 8; i++) begin
      wd[i*72 +: 72]     = beat_pat(i);
      exp_rd[i*72 +: 72] = 72'(i);
    end
    req_write = wr; req_bg = 2'd1; req_ba = 2'd1; req_row = 17'd1; req_col = 10'd2;
    req_wdata = wd; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 200) begin tick(); w++; end
    chk("accept_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    ncs = 0; noe = 0; nrv = 0; rdy_at = 0; rv_at = 0; bad_beats = 0;
    for (int o = 1; o <= 70; o++) begin
      if (abort_at != 0 && o == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_pins", {reset_n, cke, cs_n, act_n}, 4'b0011);
        chk("abort_a", A, 17'h0);
        chk("abort_dq", {dq_oe, dqs_t, dqs_c}, {1'b0, 18'h0, 18'h3FFFF});
        chk("abort_rd", {req_ready, rd_valid, nrv[0]}, 3'b000);
        chk("abort_rd_data", rd_data, 576'h0);
        tick(); tick();
        rst = 1'b0;
        return;
      end
      dq_in = (o >= 31 && o <= 38) ? 72'(o - 31) : 72'hBAD;
      if (!cs_n) ncs++;
      if (dq_oe) noe++;
      if (rd_valid) begin nrv++; rv_at = o; end
      if (req_ready && rdy_at == 0) rdy_at = o;
      if (wr && o >= 27 && o <= 34 && dq_out !== beat_pat(o - 27)) bad_beats++;
      case (o)
        1: begin
          chk("act_cmd", {cs_n, act_n}, 2'b00);
          chk("act_a", A, 17'h00001);
          chk("act_bgba", {bg, ba}, 4'b0101);
        end
        16: begin
          chk("rw_cmd", {cs_n, act_n}, 2'b01);
          chk("rw_a", A, wr ? 17'h10002 : 17'h14002);
        end
        27: if (wr) begin
          chk("wbeat0", dq_out, beat_pat(0));
          chk("wdqs", {dq_oe, dqs_t, dqs_c}, {1'b1, 18'h3FFFF, 18'h0});
        end
        default: ;
      endcase
      if (o == (wr ? 50 : 39)) begin
        chk("pre_cmd", {cs_n, act_n}, 2'b01);
        chk("pre_a", A, 17'h08000);
      end
      if (o != 70) tick();
    end
    chk("n_cmds", ncs, 3);
    chk("n_oe", noe, wr ? 8 : 0);
    chk("bad_beats", bad_beats, 0);
    chk("n_rdvalid", nrv, wr ? 0 : 1);
    if (!wr) begin
      chk("rdvalid_at", rv_at, 39);
      chk("rd_data", rd_data, exp_rd);
    end
    chk("ready_at", rdy_at, wr ? 65 : 54);
  endtask

  // req_valid held high: second read is taken only when req_ready returns
  task automatic b2b();
    int w, acts, pres, ncs, nrv, act2;
    req_write = 1'b0; req_valid = 1'b1; dq_in = 72'h0;
    w = 0;
    while (!req_ready && w < 200) begin tick(); w++; end
    tick();
    acts = 0; pres = 0; ncs = 0; nrv = 0; act2 = 0;
    for (int o = 1; o <= 107; o++) begin
      if (!cs_n) ncs++;
      if (!cs_n && !act_n) begin acts++; if (o > 1 && act2 == 0) act2 = o; end
      if (!cs_n && act_n && A[16:14] == 3'b010) pres++;
      if (rd_valid) nrv++;
      if (o == 107) req_valid = 1'b0;
      tick();
    end
    chk("b2b_acts", acts, 2);
    chk("b2b_pres", pres, 2);
    chk("b2b_cmds", ncs, 6);
    chk("b2b_act2_at", act2, 55);
    chk("b2b_rdvalid", nrv, 2);
    chk("b2b_ready", req_ready, 1'b1);
  endtask

  initial begin
    int rdy;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bg = '0; req_ba = '0;
    req_row = '0; req_col = '0; req_wdata = '0; dq_in = '0;
    tick(); tick(); tick();
    chk("rst_ctl", {reset_n, cke, cs_n, act_n, req_ready, rd_valid}, 6'b001100);
    chk("rst_addr", {A, bg, ba}, 21'h0);
    chk("rst_dq", {dq_out, dq_oe, dqs_t, dqs_c}, {72'h0, 1'b0, 18'h0, 18'h3FFFF});
    chk("rst_rd_data", rd_data, 576'h0);
    rst = 1'b0;
    tick();
    chk("init_pins", {reset_n, cke, req_ready}, 3'b110);
    rdy = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (req_ready) rdy++; end
    chk("init_early_ready", rdy, 0);
    tick();
    chk("init_ready", req_ready, 1'b1);

    txn(1'b1, 0);
    txn(1'b0, 0);
    b2b();
    txn(1'b1, 30);
    txn(1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/ddr4_cmd_sequencer.md
Name: ddr4_cmd_sequencer

Overview:
Upstream DDR4 command front-end that feeds the emulated dimm. It turns single-burst read/write requests into the timed DDR4 pin sequence the dimm decodes: ACT, RD or WR, data burst, PRE. It uses a closed-page policy with one request in flight. Write beats are driven onto dq/dqs, and read beats are captured from dq and returned as one wide word.

Parameters:
BGWIDTH, 2, bank-group address bits
BAWIDTH, 2, bank address bits
ADDRWIDTH, 17, row/command address bits (A[16:0])
COLWIDTH, 10, column bits
CHIPS, 18, devices per rank (dqs width)
DQWIDTH, 72, data bus width
BL, 8, burst length (one beat per clk)
TINIT, 5, clk cycles after reset before first command
TRCD, 15, ACT to RD/WR
TCL, 15, RD to first read beat
TCWL, 11, WR to first write beat
TWR, 16, last write beat to PRE
TRP, 15, PRE to next ACT/REF

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_write  in  1  1=write, 0=read
req_bg  in  BGWIDTH  bank group
req_ba  in  BAWIDTH  bank
req_row  in  ADDRWIDTH  row
req_col  in  COLWIDTH  column
req_wdata  in  BL*DQWIDTH  write burst, beat 0 in LSBs
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  BL*DQWIDTH  read burst, beat 0 in LSBs
reset_n  out  1  dimm reset
cke  out  1  clock enable
cs_n  out  1  chip select
act_n  out  1  activate
A  out  ADDRWIDTH  row/command address
bg  out  BGWIDTH  bank group
ba  out  BAWIDTH  bank
dq_out  out  DQWIDTH  write beat data
dq_oe  out  1  tristate enable for dq/dqs
dq_in  in  DQWIDTH  sampled read data
dqs_t  out  CHIPS  strobe true
dqs_c  out  CHIPS  strobe complement

Behaviour:
- Reset (async, immediate):
  - reset_n=0, cke=0, cs_n=1, act_n=1, A=0, bg=0, ba=0.
  - dq_out=0, dq_oe=0, dqs_t=0, dqs_c=all 1.
  - req_ready=0, rd_valid=0, rd_data=0.
  - State INIT.
- INIT: reset_n=1 and cke=1 from the first post-reset cycle. Go to IDLE after TINIT cycles.
- Command encoding (all outputs registered, one-cycle command):
  - ACT: cs_n=0, act_n=0, A=row.
  - Non-ACT commands use act_n=1 with A[16:14]={RAS_n,CAS_n,WE_n}.
  - RD: 101, A[COLWIDTH-1:0]=col.
  - WR: 100, A[COLWIDTH-1:0]=col.
  - PRE: 010.
  - REF: 001.
  - A[10]=0 (no auto-precharge).
  - All other cycles: DES (cs_n=1, act_n=1, A=0). bg/ba hold the latched request between commands.
- States: INIT → IDLE → ACT → WAIT_RCD → RW → WAIT_DATA → BURST → WAIT_PRE → PRE → WAIT_RP → IDLE.
- IDLE:
  - req_ready=1 only in IDLE (and no refresh pending under REFRESH_EN).
  - Accept on req_valid&&req_ready at cycle t: latch all req_* fields.
- Timing from accept at cycle t:
  - ACT on pins at t+1; RD/WR at t+1+TRCD.
  - Write: dq_oe=1, dqs_t=all 1, dqs_c=all 0, dq_out=beat i at cycles t+1+TRCD+TCWL+i for i=0..BL-1. dq_oe=0 and dqs back to reset values otherwise.
  - Read: dq_in sampled into beat i at cycles t+1+TRCD+TCL+i. rd_valid pulses on the cycle after the last beat, with rd_data stable until the next read completes.
  - PRE: last write beat+TWR; for reads, last read beat+1.
  - IDLE reached and req_ready=1 at PRE+TRP.
- Request inputs are ignored while req_ready=0.
- rst mid-operation aborts immediately to reset values; no PRE is issued and no partial rd_valid is produced.
- Counters wrap-safe: width clog2(max timing+BL)+1; timing parameters of 0 are illegal (assert in simulation).

Optional Feature:
REFRESH_EN:
- Defined: adds parameters TREFI (default 7800) and TRFC (default 350).
  - A free-running counter sets refresh_pending at each TREFI expiry.
  - In IDLE with refresh_pending, req_ready=0. Issue REF (cs_n=0, act_n=1, A[16:14]=001), wait TRFC, clear pending, then return to IDLE.
  - A pending refresh never interrupts an in-flight request; it wins over a simultaneous req_valid in IDLE.
- Undefined: no refresh logic, and REF is never issued.

Decomposition:
- Package ddr4_cmd_pkg holds:
  - Command enum (DES, ACT, RD, WR, PRE, REF).
  - State enum.
  - The A[16:14] encoding constants.
  - A function mapping command+row/col to {cs_n, act_n, A}.
- One sub-module, ddr_wait_counter: loadable down-counter with a done flag, instantiated once and reused for every wait.

Test Plan:
- Reset held 3 cycles, then released → all reset values during reset. reset_n=1 and cke=1 next cycle; req_ready=1 exactly TINIT cycles later.
- Write req bg=1, ba=1, row=1, col=2 accepted at t → ACT with A=17'h00001 at t+1; A=17'h10002, act_n=1 at t+16; dq_oe=1 with beats 0..7 at t+27..t+34; PRE A=17'h08000 at t+50; req_ready=1 at t+65.
- Read to same address, bench drives dq_in=beat index at t+31..t+38 → A=17'h14002 at t+16; rd_valid one pulse at t+39 with rd_data beat i = i.
- req_valid held high continuously for two requests → second accepted only when req_ready returns; no overlapping commands; exactly one ACT/PRE pair per request.
- rst asserted during BURST of a write → outputs to reset values within the same cycle; after re-init the next read request completes normally.
- REFRESH_EN with TREFI=100 and requests issued back-to-back → one REF per ~100 cycles, only from IDLE; next ACT no earlier than REF+TRFC.
